mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one 4x4 unsigned combinational multiplier (8-bit product) among NUM_REQ requesters.
- Each requester presents operands with a valid/ready handshake.
- The block grants one requester, registers its operands, and drives the multiplier. It then returns the registered product with the winner's ID on a valid/ready response channel.
- Sits between the multiply clients and the shared partial-product multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..8. Local ID_W = $clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  4*NUM_REQ  operand A; requester i at bits [4i+3:4i]
- req_b  in  4*NUM_REQ  operand B; same packing
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_data  out  8  product A*B, unsigned
- resp_id  out  ID_W  index of requester that issued the product
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low) clears the following immediately:
  - state=IDLE; RR pointer=0
  - req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0
  - latched operands=0
- Reset mid-operation discards any in-flight transaction; no response is produced for it.
- FSM states:
  - IDLE:
    - If any req_valid, winner = first set bit searching upward from pointer, wrapping modulo NUM_REQ.
    - req_ready[winner]=1 combinationally in the same cycle; the transfer fires.
    - Latch a, b and winner; next state=MUL.
    - If no req_valid, all req_ready=0 and the FSM stays in IDLE.
  - MUL:
    - Drive the latched operands into the shared multiplier.
    - At the clock edge, register the product into resp_data and winner into resp_id, set resp_valid=1; next state=RESP.
  - RESP:
    - Hold resp_valid, resp_data and resp_id stable until resp_ready=1.
    - On fire: resp_valid=0; pointer=(winner+1) mod NUM_REQ; next state=IDLE.
- req_ready is 0 in MUL and RESP. Requests are never accepted while a transaction is outstanding; only one is outstanding at a time.
- Latency: request fire (IDLE cycle N) -> resp_valid high at cycle N+2. Minimum issue interval is 3 cycles with resp_ready held high.
- Arithmetic:
  - Unsigned, full 8-bit result; no truncation. Max 15*15=225 (0xE1).
  - Any zero operand gives 0.
- A requester that deasserts req_valid before being granted is simply skipped; no state is kept for it.
- req_a/req_b of non-winners are ignored.
- Pointer advances only on response fire, never on grant alone. A requester held valid is served within NUM_REQ transactions (starvation-free).
- resp_ready asserted while resp_valid=0 has no effect.
- Simultaneous valids in IDLE: exactly one grant, chosen by pointer order.

Optional Feature:
- Macro MUL_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output port txn_cnt, 16 bits: count of completed response fires.
  - Reset to 0; saturates at 0xFFFF; increments in the cycle of the response fire.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_n=0 mid-RESP with resp_valid=1 -> resp_valid, req_ready and busy go 0 immediately (async); after release, first grant goes to requester 0.
- Single request: req_valid=4'b0100, a[2]=13, b[2]=11, resp_ready=1 -> req_ready=4'b0100 for one cycle; 2 cycles later resp_valid=1, resp_data=143, resp_id=2.
- Round-robin: all four valid continuously; operands per requester i: a=i+1, b=15; resp_ready=1 -> response IDs 0,1,2,3,0; resp_data 15,30,45,60,15; one response every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_data/resp_id stable, all req_ready=0, busy=1; the next grant occurs only after the fire cycle.
- Boundary values: (15,15)->225; (0,9)->0; (1,1)->1; (8,8)->64.
- Stats (macro on): 70000 transactions -> txn_cnt=0xFFFF saturated.

Source files
------------

// File: rtl/mul_share_arb_if.sv
// Handshake bundle between multiply clients and the shared-multiplier arbiter.
// Clients drive the master modport; the arbiter uses the slave modport.
interface mul_share_arb_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_data;
  logic [ID_W-1:0]      resp_id;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one 4x4 unsigned multiplier among NUM_REQ requesters.
// Optional MUL_SHARE_ARB_STATS_EN adds a saturating 16-bit completed-transaction count.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, operands latched on fire
// MUL   | latched operands drive the multiplier; product registered at edge
// RESP  | response held until resp_ready; pointer moves past winner on fire
module mul_share_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_share_arb_if.slave bus
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]   txn_cnt
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] win_q;
  logic [3:0]      op_a_q;
  logic [3:0]      op_b_q;
  logic            resp_valid_q;
  logic [7:0]      resp_data_q;
  logic [ID_W-1:0] resp_id_q;
  logic            busy_q;

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  int              idx;
  logic [3:0]      grant_a;
  logic [3:0]      grant_b;
  logic [7:0]      prod;

  // Scan downward so the candidate closest to the pointer is the last to win.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_a = bus.req_a[{grant_id, 2'b00} +: 4];
  assign grant_b = bus.req_b[{grant_id, 2'b00} +: 4];
  assign prod    = {4'b0000, op_a_q} * {4'b0000, op_b_q};

  // Gated by rst_n so no grant is offered while reset is held.
  assign bus.req_ready = (rst_n && (state_q == IDLE) && grant_vld)
                         ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = busy_q;

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] txn_q;
  assign txn_cnt = txn_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      busy_q       <= 1'b0;
`ifdef MUL_SHARE_ARB_STATS_EN
      txn_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            op_a_q  <= grant_a;
            op_b_q  <= grant_b;
            win_q   <= grant_id;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          resp_data_q  <= prod;
          resp_id_q    <= win_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ptr_q        <= (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            state_q      <= IDLE;
`ifdef MUL_SHARE_ARB_STATS_EN
            if (txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
`endif
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: vector table, scoreboard monitor and
// hand-written sequences for round-robin, backpressure and async reset.
module tb_mul_share_arb;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_cnt = 0;

  mul_share_arb_if #(.NUM_REQ(N)) bus ();

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] txn_cnt;
`endif

  mul_share_arb #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .txn_cnt (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / reference model, evaluated at every falling edge
  typedef struct { int id; int data; } exp_t;
  exp_t sb[$];
  int   m_state = 0;
  int   m_ptr   = 0;
  int   m_txn   = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int   w;
    bit   found;
    exp_t e;
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      m_txn   = 0;
      sb.delete();
    end else begin
      found   = 0;
      w       = 0;
      exp_rdy = '0;
      if (m_state == 0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && bus.req_valid[(m_ptr + k) % N]) begin
            found = 1;
            w     = (m_ptr + k) % N;
          end
        end
        if (found) exp_rdy[w] = 1'b1;
      end
      chk("mon_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("mon_busy", 32'(bus.busy), 32'(m_state != 0));
      chk("mon_resp_valid", 32'(bus.resp_valid), 32'(m_state == 2));
      if (m_state == 2) begin
        if (sb.size() == 0) chk("mon_sb_empty", 32'd1, 32'd0);
        else begin
          chk("mon_resp_id", 32'(bus.resp_id), 32'(sb[0].id));
          chk("mon_resp_data", 32'(bus.resp_data), 32'(sb[0].data));
        end
      end
      case (m_state)
        0: if (found) begin
          e.id   = w;
          e.data = int'(bus.req_a[4*w +: 4]) * int'(bus.req_b[4*w +: 4]);
          sb.push_back(e);
          m_state = 1;
        end
        1: m_state = 2;
        default: if (bus.resp_ready) begin
          if (sb.size() != 0) begin
            e     = sb.pop_front();
            m_ptr = (e.id + 1) % N;
          end
          m_txn++;
          m_state = 0;
        end
      endcase
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    int          exp_id;
    int          exp_data;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int got;
    int ids[5];
    int dats[5];
    int tms[5];

    vecs[0] = '{4'b0100, 16'h0D00, 16'h0B00, 2, 143};
    vecs[1] = '{4'b0001, 16'h000F, 16'h000F, 0, 225};
    vecs[2] = '{4'b0010, 16'h0000, 16'h0090, 1, 0};
    vecs[3] = '{4'b1000, 16'h1000, 16'h1000, 3, 1};
    vecs[4] = '{4'b0100, 16'h0800, 16'h0800, 2, 64};
    vecs[5] = '{4'b0111, 16'h9876, 16'h3333, 0, 18};
    vecs[6] = '{4'b1101, 16'h9876, 16'h2222, 2, 16};
    vecs[7] = '{4'b0011, 16'hFEDC, 16'h000A, 0, 120};
    vecs[8] = '{4'b1000, 16'hF000, 16'h0000, 3, 0};

    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    #2;
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_resp_data", 32'(bus.resp_data), 0);
    chk("rst_resp_id", 32'(bus.resp_id), 0);
    cyc(); cyc();
    rst_n          = 1'b1;
    bus.resp_ready = 1'b1;

    // Vector table: one transaction each, latency and result checked
    foreach (vecs[i]) begin
      cyc();
      bus.req_valid = vecs[i].valid;
      bus.req_a     = vecs[i].a;
      bus.req_b     = vecs[i].b;
      @(negedge clk);
      n = 0;
      while (bus.req_ready == '0 && n < 8) begin
        cyc(); @(negedge clk); n++;
      end
      chk("vec_req_ready", 32'(bus.req_ready), 32'(1) << vecs[i].exp_id);
      cyc();
      bus.req_valid = '0;
      @(negedge clk);
      chk("vec_lat_n1", 32'(bus.resp_valid), 0);
      cyc();
      @(negedge clk);
      chk("vec_lat_n2", 32'(bus.resp_valid), 1);
      chk("vec_resp_data", 32'(bus.resp_data), 32'(vecs[i].exp_data));
      chk("vec_resp_id", 32'(bus.resp_id), 32'(vecs[i].exp_id));
      cyc();
    end

    // Round-robin with all requesters valid
    cyc();
    bus.req_valid = 4'b1111;
    bus.req_a     = 16'h4321;
    bus.req_b     = 16'hFFFF;
    got = 0;
    n   = 0;
    while (got < 5 && n < 60) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin
        ids[got]  = int'(bus.resp_id);
        dats[got] = int'(bus.resp_data);
        tms[got]  = cyc_cnt;
        got++;
      end
      n++;
    end
    chk("rr_count", 32'(got), 5);
    for (int i = 0; i < got; i++) begin
      chk("rr_id", 32'(ids[i]), 32'(i % 4));
      chk("rr_data", 32'(dats[i]), 32'(((i % 4) + 1) * 15));
      if (i > 0) chk("rr_interval", 32'(tms[i] - tms[i-1]), 3);
    end
    cyc();
    bus.req_valid = '0;
    n = 0;
    while (bus.busy && n < 10) begin @(negedge clk); n++; end
    chk("rr_drain", 32'(bus.busy), 0);

    // Backpressure: pointer is 1, requester 1 computes 5*5
    cyc();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b1111;
    bus.req_a      = 16'h0050;
    bus.req_b      = 16'h0050;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_data", 32'(bus.resp_data), 25);
      chk("bp_resp_id", 32'(bus.resp_id), 1);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_busy", 32'(bus.busy), 1);
      @(negedge clk);
    end
    cyc();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_fire_req_ready", 32'(bus.req_ready), 0);
    chk("bp_fire_valid", 32'(bus.resp_valid), 1);
    cyc();
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.req_ready), 32'h4);
    cyc();
    bus.req_valid = '0;
    n = 0;
    while (bus.busy && n < 10) begin @(negedge clk); n++; end
    chk("bp_drain", 32'(bus.busy), 0);

    // Async reset while a response is pending; pointer would otherwise be 3
    cyc();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0001;
    bus.req_a      = 16'h0007;
    bus.req_b      = 16'h0003;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
    chk("ar_pre_valid", 32'(bus.resp_valid), 1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("ar_resp_valid", 32'(bus.resp_valid), 0);
    chk("ar_req_ready", 32'(bus.req_ready), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_resp_data", 32'(bus.resp_data), 0);
    cyc(); cyc();
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_first_grant", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = '0;
    n = 0;
    while (bus.busy && n < 10) begin @(negedge clk); n++; end
    chk("ar_drain", 32'(bus.busy), 0);

`ifdef MUL_SHARE_ARB_STATS_EN
    @(negedge clk);
    chk("stats_txn_cnt", 32'(txn_cnt), 32'(m_txn));
`endif

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
